// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read ports and the flush handshake.
// The datapath side is the master; the register file is the slave.
interface reg_file_param_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
);

    // Write port (from writeback)
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  d_in;

    // Read ports (to operand fetch)
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  d_out_a;
    logic [WIDTH-1:0]  d_out_b;

    // Flush handshake and dropped-write flag
    logic              clr_req;
    logic              clr_busy;
    logic              wr_err;

    modport master (
        output wr,
        output wr_addr,
        output d_in,
        output rd_addr_a,
        output rd_addr_b,
        output clr_req,
        input  d_out_a,
        input  d_out_b,
        input  clr_busy,
        input  wr_err
    );

    modport slave (
        input  wr,
        input  wr_addr,
        input  d_in,
        input  rd_addr_a,
        input  rd_addr_b,
        input  clr_req,
        output d_out_a,
        output d_out_b,
        output clr_busy,
        output wr_err
    );

endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: 2^ADDR_W words of WIDTH bits, one write port, two
// combinational read ports, optional write-to-read bypass, optional hardwired-zero
// register 0, and a one-word-per-cycle flush engine with a busy handshake.
module reg_file_param #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input logic             clk,
    input logic             reset,
    reg_file_param_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_err_q, wr_err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              busy;
    logic              wr_accept;
    logic              ptr_last;
    logic [WIDTH-1:0]  rd_a;
    logic [WIDTH-1:0]  rd_b;

    assign ptr_last = (ptr_q == {ADDR_W{1'b1}});

    // FSM state, flush pointer and dropped-write flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Next-state logic: clr_req is only looked at in idle; a flush walks every word once.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                // Wraps back to zero on the last word, so idle always restarts at 0.
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_last) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM outputs: busy flag, write acceptance and the dropped-write pulse.
    always_comb begin
        busy      = (state_q == StClear);
        wr_accept = bus.wr && !busy && !(ZERO_R0 && (bus.wr_addr == '0));
        wr_err_d  = bus.wr && busy;
    end

    // Storage array: reset clears everything, a flush clears one word per cycle and
    // takes priority, otherwise an accepted write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (busy) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_accept) begin
            mem_q[bus.wr_addr] <= bus.d_in;
        end
    end

    // Read port A: stored word, optionally forwarded from a same-cycle write, r0 forced low.
    always_comb begin
        rd_a = mem_q[bus.rd_addr_a];
        if (BYPASS && wr_accept && (bus.wr_addr == bus.rd_addr_a)) begin
            rd_a = bus.d_in;
        end
        if (ZERO_R0 && (bus.rd_addr_a == '0)) begin
            rd_a = '0;
        end
    end

    // Read port B: same rules as port A, evaluated independently.
    always_comb begin
        rd_b = mem_q[bus.rd_addr_b];
        if (BYPASS && wr_accept && (bus.wr_addr == bus.rd_addr_b)) begin
            rd_b = bus.d_in;
        end
        if (ZERO_R0 && (bus.rd_addr_b == '0)) begin
            rd_b = '0;
        end
    end

    assign bus.d_out_a  = rd_a;
    assign bus.d_out_b  = rd_b;
    assign bus.clr_busy = busy;
    assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: four differently parametrised instances share one stimulus
// stream and are each compared every cycle against a word-array reference model.
module tb_reg_file_param;

    localparam int NCFG = 4;

    function automatic int unsigned cfg_w(input int g);
        case (g)
            0: return 16;
            1: return 16;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned cfg_aw(input int g);
        case (g)
            0: return 3;
            1: return 3;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit cfg_byp(input int g);
        case (g)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit cfg_z(input int g);
        case (g)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic        clr_req;
    logic [2:0]  wr_addr;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [31:0] d_in;

    logic [NCFG-1:0][31:0] dout_a;
    logic [NCFG-1:0][31:0] dout_b;
    logic [NCFG-1:0]       busy_o;
    logic [NCFG-1:0]       err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned W  = cfg_w(g);
        localparam int unsigned AW = cfg_aw(g);

        reg_file_param_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

        assign bus.wr        = wr;
        assign bus.wr_addr   = wr_addr[AW-1:0];
        assign bus.d_in      = d_in[W-1:0];
        assign bus.rd_addr_a = ra[AW-1:0];
        assign bus.rd_addr_b = rb[AW-1:0];
        assign bus.clr_req   = clr_req;
        assign dout_a[g]     = 32'(bus.d_out_a);
        assign dout_b[g]     = 32'(bus.d_out_b);
        assign busy_o[g]     = bus.clr_busy;
        assign err_o[g]      = bus.wr_err;

        reg_file_param #(
            .WIDTH  (W),
            .ADDR_W (AW),
            .BYPASS (cfg_byp(g)),
            .ZERO_R0(cfg_z(g))
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    // Reference model: word contents, flush progress and pending error flag per instance.
    logic [31:0] m_mem  [NCFG][8];
    bit          m_busy [NCFG];
    int          m_idx  [NCFG];
    bit          m_err  [NCFG];

    function automatic int depth(input int g);
        return 1 << cfg_aw(g);
    endfunction

    function automatic logic [31:0] msk(input int g, input logic [31:0] v);
        logic [63:0] m;
        m = (64'd1 << cfg_w(g)) - 64'd1;
        return v & m[31:0];
    endfunction

    function automatic bit accepted(input int g);
        int wa;
        wa = int'(wr_addr) % depth(g);
        return (wr === 1'b1) && !m_busy[g] && !(cfg_z(g) && wa == 0);
    endfunction

    function automatic logic [31:0] exp_read(input int g, input logic [2:0] addr);
        int a;
        int wa;
        a  = int'(addr) % depth(g);
        wa = int'(wr_addr) % depth(g);
        if (cfg_z(g) && a == 0) return 32'd0;
        if (cfg_byp(g) && accepted(g) && wa == a) return msk(g, d_in);
        return m_mem[g][a];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NCFG; g++) begin
            check_eq($sformatf("cfg%0d d_out_a[%0d]", g, ra), dout_a[g], exp_read(g, ra));
            check_eq($sformatf("cfg%0d d_out_b[%0d]", g, rb), dout_b[g], exp_read(g, rb));
            check_eq($sformatf("cfg%0d clr_busy", g), 32'(busy_o[g]), 32'(m_busy[g]));
            check_eq($sformatf("cfg%0d wr_err", g), 32'(err_o[g]), 32'(m_err[g]));
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NCFG; g++) begin
            for (int i = 0; i < 8; i++) m_mem[g][i] = 32'd0;
            m_busy[g] = 1'b0;
            m_idx[g]  = 0;
            m_err[g]  = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int g = 0; g < NCFG; g++) begin
            int wa;
            bit acc;
            wa       = int'(wr_addr) % depth(g);
            acc      = accepted(g);
            m_err[g] = (wr === 1'b1) && m_busy[g];
            if (m_busy[g]) begin
                m_mem[g][m_idx[g]] = 32'd0;
                m_idx[g]++;
                if (m_idx[g] == depth(g)) m_busy[g] = 1'b0;
            end else begin
                if (acc) m_mem[g][wa] = msk(g, d_in);
                if (clr_req === 1'b1) begin
                    m_busy[g] = 1'b1;
                    m_idx[g]  = 0;
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic settle_check();
        #1;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle_check();
        advance();
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [31:0] d,
                         input logic [2:0] a, input logic [2:0] b, input logic c);
        wr = w; wr_addr = wa; d_in = d; ra = a; rb = b; clr_req = c;
    endtask

    // Asynchronous reset asserted mid-cycle, checked straight away on several addresses.
    task automatic apply_reset();
        wr = 1'b0;
        clr_req = 1'b0;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            ra = 3'(i);
            rb = 3'(7 - i);
            settle_check();
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 3'd0, 32'd0, 3'($urandom), 3'($urandom), 1'b0);
            tick();
        end
    endtask

    initial begin
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Reset contents, then basic write and read-back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 32'd0, 3'(i), 3'(7 - i), 1'b0);
            tick();
        end
        drive(1'b1, 3'd3, 32'h0000_A5A5, 3'd0, 3'd1, 1'b0); tick();
        drive(1'b1, 3'd7, 32'h0000_1234, 3'd2, 3'd4, 1'b0); tick();
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd7, 1'b0);
        settle_check();
        check_eq("lit cfg0 r3", dout_a[0], 32'h0000_A5A5);
        check_eq("lit cfg0 r7", dout_b[0], 32'h0000_1234);
        advance();

        // Bypass versus stored-only reads on a same-cycle write.
        drive(1'b1, 3'd2, 32'h0000_0001, 3'd0, 3'd0, 1'b0); tick();
        drive(1'b1, 3'd2, 32'h0000_BEEF, 3'd2, 3'd2, 1'b0);
        settle_check();
        check_eq("lit bypass cfg1 a", dout_a[1], 32'h0000_BEEF);
        check_eq("lit bypass cfg1 b", dout_b[1], 32'h0000_BEEF);
        check_eq("lit nobypass cfg0", dout_a[0], 32'h0000_0001);
        advance();
        drive(1'b0, 3'd0, 32'd0, 3'd2, 3'd2, 1'b0);
        settle_check();
        check_eq("lit nobypass cfg0 next", dout_a[0], 32'h0000_BEEF);
        advance();

        // Hardwired zero register.
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 3'd1, 1'b0); tick();
        drive(1'b1, 3'd1, 32'hFFFF_FFFF, 3'd0, 3'd1, 1'b0); tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd1, 1'b0);
        settle_check();
        check_eq("lit zero_r0 cfg1 r0", dout_a[1], 32'd0);
        check_eq("lit zero_r0 cfg1 r1", dout_b[1], 32'h0000_FFFF);
        advance();

        // Flush: fill, request, spurious request mid-flush, dropped write, then drain.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'h1111 * (i + 1), 3'(i), 3'($urandom), 1'b0);
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd7, 1'b1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 32'd0, 3'(i), 3'(i + 4), (i == 1));
            tick();
        end
        drive(1'b1, 3'd5, 32'h0000_7777, 3'd3, 3'd4, 1'b0);
        settle_check();
        check_eq("lit midflush cfg0 r3", dout_a[0], 32'd0);
        check_eq("lit midflush cfg0 r4", dout_b[0], 32'h0000_5555);
        advance();
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd6, 1'b0);
        settle_check();
        check_eq("lit dropped cfg0 r5", dout_a[0], 32'h0000_6666);
        check_eq("lit dropped cfg0 wr_err", 32'(err_o[0]), 32'd1);
        advance();
        idle_ticks(8);

        // Write and flush request in the same idle cycle.
        drive(1'b1, 3'd0, 32'h0000_7777, 3'd0, 3'd0, 1'b1); tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd1, 1'b0);
        settle_check();
        check_eq("lit wr+clr cfg0 r0", dout_a[0], 32'h0000_7777);
        advance();
        idle_ticks(8);

        // Reset in the third flush cycle.
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1); tick();
        idle_ticks(2);
        apply_reset();
        idle_ticks(2);

        // Randomised traffic with occasional flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom), 3'($urandom), $urandom, 3'($urandom), 3'($urandom),
                  ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-port register file; the next generation of the fixed 8×16 register file. It stores 2^ADDR_W words of WIDTH bits, with one write port and two asynchronous read ports. It adds optional write-to-read bypass, an optional hardwired-zero register 0, and a sequential flush engine that clears the array one word per cycle under a busy handshake. It sits between the datapath's writeback stage and its operand-fetch stage.

## Interface
- WIDTH, 16, word width in bits (≥1).
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W words (1..8).
- BYPASS, 1, 1 = a same-cycle accepted write is forwarded to matching read ports; 0 = reads see stored contents only.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears the array, FSM, pointer and wr_err.
- wr  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- d_in  in  WIDTH  write data.
- rd_addr_a  in  ADDR_W  read address, port A.
- rd_addr_b  in  ADDR_W  read address, port B.
- d_out_a  out  WIDTH  read data, port A (combinational).
- d_out_b  out  WIDTH  read data, port B (combinational).
- clr_req  in  1  flush request, sampled in IDLE only.
- clr_busy  out  1  high while the flush is in progress.
- wr_err  out  1  registered one-cycle pulse flagging a write dropped during a flush.

All vectors are [N-1:0], with bit 0 as the LSB.

## Operation
- **Write accept.** A write is accepted when wr=1, clr_busy=0, and not (ZERO_R0=1 and wr_addr=0). On an accepted write, mem[wr_addr] ← d_in at the edge.
- **Reads.** d_out_x = mem[rd_addr_x] combinationally.
  - ZERO_R0=1 and rd_addr_x=0: output 0.
  - BYPASS=1 and an accepted write has wr_addr=rd_addr_x: output d_in. This applies to both ports independently.
- **FSM states.** IDLE and CLEAR.
  - IDLE: when clr_req=1, go to CLEAR and set ptr ← 0.
  - CLEAR: each cycle mem[ptr] ← 0 and ptr ← ptr+1. When ptr = DEPTH−1 is cleared, go to IDLE.
- **clr_busy.** clr_busy = (state==CLEAR).
- **Flush timing.** A flush takes exactly DEPTH cycles. clr_req is ignored while in CLEAR.
- **Reads during CLEAR.** Reads return current contents: words already cleared read 0, the rest read old data. Bypass never fires in CLEAR because no write is accepted.
- **Dropped writes.** wr=1 while clr_busy=1 drops the write and sets wr_err=1 for the next cycle only.
- **clr_req with wr in IDLE.** The write is accepted that cycle; the flush starts next cycle and will clear that word.
- **Reset mid-flush.** The array is zeroed, the FSM returns to IDLE and ptr=0 immediately. There is no resumption.

## Timing
- Reset values: all mem words 0, state IDLE, ptr 0, clr_busy 0, wr_err 0. Therefore d_out_a = d_out_b = 0 until the first accepted write.
- Write-to-read latency:
  - BYPASS=1: 0 cycles (same cycle).
  - BYPASS=0: visible in the cycle after the edge.
- Read path is purely combinational: address to data, no register.
- clr_req=1 sampled at edge N:
  - clr_busy rises after edge N.
  - Words 0..DEPTH−1 are cleared at edges N+1..N+DEPTH.
  - clr_busy falls after edge N+DEPTH.
  - A write can be accepted in the cycle following edge N+DEPTH.
- wr_err is high for exactly the one cycle after each edge at which a write was dropped. Back-to-back drops keep it high continuously.
- Reset is asynchronous on assertion; release is used synchronously relative to clk.

## Test plan
- **Reset and write/read (WIDTH=16, ADDR_W=3, BYPASS=0).** Assert reset, then write 0xA5A5→r3 and 0x1234→r7. Read a=3, b=7 the next cycle → 0xA5A5 / 0x1234. All other addresses read 0.
- **Bypass (BYPASS=1).** With r2=0x0001, drive wr=1, wr_addr=2, d_in=0xBEEF, rd_addr_a=2, rd_addr_b=2 in the same cycle → both ports read 0xBEEF in that cycle. With BYPASS=0 the same stimulus → 0x0001 that cycle, 0xBEEF the next.
- **ZERO_R0=1.** Write 0xFFFF→r0 → d_out reads 0 forever. Write 0xFFFF→r1 → reads 0xFFFF.
- **Flush.** Fill r0..r7 with 0x1111·(i+1), then pulse clr_req → clr_busy high for exactly 8 cycles. Midway after 4 cleared words: r0..r3=0, r4=0x5555. After the flush all words are 0. clr_req pulsed during the flush changes nothing.
- **Write during flush.** wr=1 with wr_addr=5, d_in=0x7777 while busy → r5 is unchanged by the write and wr_err=1 for one cycle. In the same cycle as clr_req in IDLE, write 0x7777→r0 → that cycle's write lands, then r0=0 after the first flush cycle.
- **Reset mid-flush and parameter sweep.** Assert reset at flush cycle 3 → clr_busy=0 and all words 0 asynchronously. Rerun the first and fourth scenarios with WIDTH=8 and ADDR_W=2 (flush = 4 cycles), and with WIDTH=32 and ADDR_W=1.
